// File: rtl/alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq -- ALU control decoder with an optional multi-cycle sequencer
//
// Decodes the main-decoder ALUOp class and the R-type Funct field into a
// registered ALU control code. Multiply/divide Functs, when the feature is
// built in, hand control to a small sequencer that strobes the iterative
// datapath once per cycle for MD_CYCLES cycles and then reports completion.
//
// Build option:
//   ALU_CTRL_SEQ_MD_EN  defined   -> multiply/divide sequencer (IDLE/ITER/DONE)
//                       undefined -> MULT/MULTU/DIV/DIVU decode as illegal,
//                                    busy_o/md_step_o/md_done_o/md_count_o = 0
//
// Parameters:
//   CTRL_W     ALUCtrl width (>= 4, bits above [3] always 0)
//   MD_CYCLES  iterations per multiply/divide (2..64)
//   CNT_W      md_count_o width, must hold MD_CYCLES-1
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   valid_i       decode request
//   ALUOp         main-decoder operation class
//   Funct         R-type function field
//   flush_i       synchronous abort of any request or multi-cycle op
//   ready_o       a request presented this cycle will be accepted
//   ALUCtrl       registered ALU control code
//   ctrl_valid_o  pulse: ALUCtrl carries a new result
//   illegal_o     pulse: unsupported Funct was decoded
//   busy_o        multi-cycle op in progress
//   md_step_o     iteration strobe to the multiply/divide datapath
//   md_count_o    current iteration index
//   md_done_o     pulse: multi-cycle op complete
// -----------------------------------------------------------------------------
module alu_ctrl_seq #(
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        Funct,
  input  logic              flush_i,
  output logic              ready_o,
  output logic [CTRL_W-1:0] ALUCtrl,
  output logic              ctrl_valid_o,
  output logic              illegal_o,
  output logic              busy_o,
  output logic              md_step_o,
  output logic [CNT_W-1:0]  md_count_o,
  output logic              md_done_o
);

  // Elaboration-time parameter sanity checks.
  if (CTRL_W < 4) begin : g_bad_ctrl_w
    $error("alu_ctrl_seq: CTRL_W must be >= 4");
  end
  if (MD_CYCLES < 2 || MD_CYCLES > 64) begin : g_bad_md_cycles
    $error("alu_ctrl_seq: MD_CYCLES must be in 2..64");
  end
  if ((MD_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("alu_ctrl_seq: CNT_W too narrow for MD_CYCLES-1");
  end

  // Classification of a decoded request.
  typedef enum logic [1:0] {
    K_SINGLE  = 2'd0,
    K_ILLEGAL = 2'd1,
    K_MD      = 2'd2
  } kind_e;

  kind_e       dec_kind;
  logic [3:0]  dec_code;
  logic        accept;

  logic [CTRL_W-1:0] ctrl_q;
  logic              ctrl_valid_q;
  logic              illegal_q;

  // Combinational decode of the presented request.
  always_comb begin
    dec_kind = K_SINGLE;
    dec_code = 4'b0000;
    case (ALUOp)
      2'b00:   dec_code = 4'b0100;
      2'b01:   dec_code = 4'b0110;
      2'b11:   dec_code = 4'b0000;
      default: begin
        case (Funct)
          6'b100000: dec_code = 4'b0100;
          6'b100001: dec_code = 4'b0101;
          6'b100010: dec_code = 4'b0110;
          6'b100011: dec_code = 4'b1110;
          6'b100100: dec_code = 4'b0000;
          6'b100101: dec_code = 4'b0001;
          6'b100110: dec_code = 4'b1001;
          6'b100111: dec_code = 4'b1000;
          6'b101010: dec_code = 4'b0011;
          6'b101011: dec_code = 4'b1011;
          6'b000100: dec_code = 4'b0010;
          6'b000110: dec_code = 4'b0111;
          6'b000111: dec_code = 4'b1010;
          // MULT / MULTU / DIV / DIVU
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
`ifdef ALU_CTRL_SEQ_MD_EN
            dec_kind = K_MD;
            dec_code = 4'b1111;
`else
            dec_kind = K_ILLEGAL;
            dec_code = 4'b0000;
`endif
          end
          default: begin
            dec_kind = K_ILLEGAL;
            dec_code = 4'b0000;
          end
        endcase
      end
    endcase
  end

  assign accept = valid_i & ready_o;

`ifdef ALU_CTRL_SEQ_MD_EN

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MD_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             step_q;
  logic             done_q;

  // Reset is folded in so ready_o drops the moment rst rises.
  assign ready_o = ~rst & ~flush_i & (state_q == S_IDLE);

  // Controller: all outputs are registered alongside the state so that the
  // ITER/DONE indications line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      busy_q       <= 1'b0;
      step_q       <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      // Pulse outputs default low every cycle.
      ctrl_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ctrl_q <= CTRL_W'(dec_code);
            case (dec_kind)
              K_MD: begin
                state_q <= S_ITER;
                busy_q  <= 1'b1;
                step_q  <= 1'b1;
                count_q <= '0;
              end
              K_ILLEGAL: begin
                ctrl_valid_q <= 1'b1;
                illegal_q    <= 1'b1;
              end
              default: ctrl_valid_q <= 1'b1;
            endcase
          end
        end
        S_ITER: begin
          if (flush_i) begin
            // Abort silently; ALUCtrl keeps the 1111 code.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            count_q <= '0;
          end else if (count_q == LAST_CNT) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            step_q       <= 1'b0;
            count_q      <= '0;
            done_q       <= 1'b1;
            ctrl_valid_q <= 1'b1;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          // Always returns to IDLE; a flush here changes nothing further.
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          step_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign md_step_o  = step_q;
  assign md_count_o = count_q;
  assign md_done_o  = done_q;

`else

  // Without the sequencer the block never leaves IDLE.
  assign ready_o = ~rst & ~flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      ctrl_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      if (accept) begin
        ctrl_q       <= CTRL_W'(dec_code);
        ctrl_valid_q <= 1'b1;
        illegal_q    <= (dec_kind == K_ILLEGAL);
      end
    end
  end

  assign busy_o     = 1'b0;
  assign md_step_o  = 1'b0;
  assign md_count_o = '0;
  assign md_done_o  = 1'b0;

`endif

  assign ALUCtrl      = ctrl_q;
  assign ctrl_valid_o = ctrl_valid_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_seq -- self-checking bench for alu_ctrl_seq
//
// Reference model tracks a multi-cycle op only by the cycle number at which it
// was accepted; every expected output is derived from the offset of the
// current cycle relative to that start. Decode uses a lookup table.
// Works with or without ALU_CTRL_SEQ_MD_EN defined.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_seq;

  localparam int CTRL_W = 5;
  localparam int MD     = 32;
  localparam int CNT_W  = 6;

  logic              clk;
  logic              rst;
  logic              valid_i;
  logic [1:0]        ALUOp;
  logic [5:0]        Funct;
  logic              flush_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ALUCtrl;
  logic              ctrl_valid_o;
  logic              illegal_o;
  logic              busy_o;
  logic              md_step_o;
  logic [CNT_W-1:0]  md_count_o;
  logic              md_done_o;

  alu_ctrl_seq #(
    .CTRL_W   (CTRL_W),
    .MD_CYCLES(MD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ALUOp       (ALUOp),
    .Funct       (Funct),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .ALUCtrl     (ALUCtrl),
    .ctrl_valid_o(ctrl_valid_o),
    .illegal_o   (illegal_o),
    .busy_o      (busy_o),
    .md_step_o   (md_step_o),
    .md_count_o  (md_count_o),
    .md_done_o   (md_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state
  int         md_start = -1;
  logic [3:0] e_ctrl   = 4'b0000;
  logic       e_cv, e_ill;

  typedef struct {
    logic [5:0] f;
    logic [3:0] c;
  } fmap_t;

  fmap_t fmap [0:12] = '{
    '{6'b100000, 4'b0100}, '{6'b100001, 4'b0101}, '{6'b100010, 4'b0110},
    '{6'b100011, 4'b1110}, '{6'b100100, 4'b0000}, '{6'b100101, 4'b0001},
    '{6'b100110, 4'b1001}, '{6'b100111, 4'b1000}, '{6'b101010, 4'b0011},
    '{6'b101011, 4'b1011}, '{6'b000100, 4'b0010}, '{6'b000110, 4'b0111},
    '{6'b000111, 4'b1010}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // kind: 0 single-cycle, 1 illegal, 2 multiply/divide
  task automatic ref_decode(input logic [1:0] op, input logic [5:0] f,
                            output logic [3:0] code, output int kind);
    kind = 0;
    code = 4'b0000;
    if (op == 2'b00) code = 4'b0100;
    else if (op == 2'b01) code = 4'b0110;
    else if (op == 2'b11) code = 4'b0000;
    else begin
      kind = 1;
      for (int i = 0; i < 13; i++)
        if (fmap[i].f == f) begin
          kind = 0;
          code = fmap[i].c;
        end
`ifdef ALU_CTRL_SEQ_MD_EN
      if (f[5:2] == 4'b0110) begin
        kind = 2;
        code = 4'b1111;
      end
`endif
    end
  endtask

  // One clock cycle: drive inputs, check ready_o, advance model, check outputs.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [5:0] f, input logic fl);
    int         off;
    bit         in_md, acc, e_busy, e_done;
    int         e_cnt, kind;
    logic [3:0] code;
    valid_i = v;
    ALUOp   = op;
    Funct   = f;
    flush_i = fl;
    #1;
    off   = (md_start < 0) ? -1 : cyc - md_start;
    in_md = (off >= 1) && (off <= MD + 1);
    chk("ready", ready_o, (!in_md && !fl));
    acc  = v && !in_md && !fl;
    e_cv = 1'b0;
    e_ill = 1'b0;
    if (in_md && (fl || off == MD + 1)) md_start = -1;
    if (acc) begin
      ref_decode(op, f, code, kind);
      e_ctrl = code;
      if (kind == 2) md_start = cyc;
      else begin
        e_cv  = 1'b1;
        e_ill = (kind == 1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    off    = (md_start < 0) ? -1 : cyc - md_start;
    e_busy = (off >= 1) && (off <= MD);
    e_cnt  = e_busy ? off - 1 : 0;
    e_done = (off == MD + 1);
    if (e_done) e_cv = 1'b1;
    chk("alu_ctrl",   ALUCtrl, {28'b0, e_ctrl});
    chk("ctrl_valid", ctrl_valid_o, e_cv);
    chk("illegal",    illegal_o, e_ill);
    chk("busy",       busy_o, e_busy);
    chk("md_step",    md_step_o, e_busy);
    chk("md_count",   md_count_o, e_cnt);
    chk("md_done",    md_done_o, e_done);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},   ready_o, 0);
    chk({tag, "_ctrl"},    ALUCtrl, 0);
    chk({tag, "_cv"},      ctrl_valid_o, 0);
    chk({tag, "_ill"},     illegal_o, 0);
    chk({tag, "_busy"},    busy_o, 0);
    chk({tag, "_step"},    md_step_o, 0);
    chk({tag, "_count"},   md_count_o, 0);
    chk({tag, "_done"},    md_done_o, 0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] exp_ctrl;
    logic       exp_ill;
  } vec_t;

  vec_t vecs [$];

  logic [5:0] fpool [0:9] = '{6'b100000, 6'b101010, 6'b100011, 6'b000111, 6'b011000,
                              6'b011011, 6'b111111, 6'b000000, 6'b100111, 6'b011010};

  initial begin
    int steps, done_off;
    rst     = 1'b1;
    valid_i = 1'b0;
    ALUOp   = 2'b00;
    Funct   = 6'b0;
    flush_i = 1'b0;

    // Reset state
    #1;
    chk_all_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    rst = 1'b0;

    // Table-driven decode vectors
    vecs.push_back('{2'b10, 6'b101010, 4'b0011, 1'b0});
    vecs.push_back('{2'b00, 6'b111111, 4'b0100, 1'b0});
    vecs.push_back('{2'b01, 6'b000000, 4'b0110, 1'b0});
    vecs.push_back('{2'b11, 6'b100000, 4'b0000, 1'b0});
    vecs.push_back('{2'b10, 6'b100011, 4'b1110, 1'b0});
    vecs.push_back('{2'b10, 6'b100110, 4'b1001, 1'b0});
    vecs.push_back('{2'b10, 6'b111111, 4'b0000, 1'b1});
    vecs.push_back('{2'b10, 6'b101011, 4'b1011, 1'b0});
    vecs.push_back('{2'b10, 6'b000111, 4'b1010, 1'b0});
    vecs.push_back('{2'b10, 6'b000000, 4'b0000, 1'b1});
    vecs.push_back('{2'b10, 6'b000100, 4'b0010, 1'b0});
`ifndef ALU_CTRL_SEQ_MD_EN
    vecs.push_back('{2'b10, 6'b011010, 4'b0000, 1'b1});
    vecs.push_back('{2'b10, 6'b011000, 4'b0000, 1'b1});
`endif
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].op, vecs[i].f, 1'b0);
      chk("vec_ctrl", ALUCtrl, {28'b0, vecs[i].exp_ctrl});
      chk("vec_ill",  illegal_o, vecs[i].exp_ill);
      chk("vec_cv",   ctrl_valid_o, 1);
      chk("vec_busy", busy_o, 0);
    end
    cycle(1'b0, 2'b00, 6'b0, 1'b0);
    chk("cv_one_cycle", ctrl_valid_o, 0);

    // Flush with valid in IDLE drops the request
    cycle(1'b1, 2'b00, 6'b0, 1'b1);
    chk("flush_drop_cv", ctrl_valid_o, 0);

`ifdef ALU_CTRL_SEQ_MD_EN
    // MULT runs to completion
    cycle(1'b1, 2'b10, 6'b011000, 1'b0);
    chk("mult_ctrl", ALUCtrl, 5'b01111);
    steps = (md_step_o === 1'b1) ? 1 : 0;
    done_off = -1;
    for (int k = 2; k <= 40; k++) begin
      cycle(1'b0, 2'b00, 6'b0, 1'b0);
      if (md_step_o === 1'b1) steps++;
      if (md_done_o === 1'b1 && done_off < 0) done_off = k;
    end
    chk("mult_steps", steps, MD);
    chk("mult_done_off", done_off, MD + 1);
    #1;
    chk("mult_ready_after", ready_o, 1);

    // MULT flushed at md_count_o == 5
    cycle(1'b1, 2'b10, 6'b011001, 1'b0);
    for (int k = 0; k < 10 && md_count_o != 5; k++) cycle(1'b0, 2'b00, 6'b0, 1'b0);
    chk("flush_at5_cnt", md_count_o, 5);
    cycle(1'b0, 2'b00, 6'b0, 1'b1);
    chk("flush_busy", busy_o, 0);
    for (int k = 0; k < 30; k++) begin
      cycle(1'b0, 2'b00, 6'b0, 1'b0);
      chk("flush_no_done", md_done_o, 0);
    end
    cycle(1'b1, 2'b00, 6'b0, 1'b0);
    chk("after_flush_ctrl", ALUCtrl, 5'b00100);

    // DIV aborted by async reset at md_count_o == 10
    cycle(1'b1, 2'b10, 6'b011010, 1'b0);
    for (int k = 0; k < 15 && md_count_o != 10; k++) cycle(1'b0, 2'b00, 6'b0, 1'b0);
    chk("div_cnt10", md_count_o, 10);
    rst = 1'b1;
    #1;
    chk_all_zero("div_rst_async");
    @(posedge clk);
    #1;
    chk_all_zero("div_rst_hold");
    rst      = 1'b0;
    md_start = -1;
    e_ctrl   = 4'b0000;
    cycle(1'b1, 2'b01, 6'b0, 1'b0);
    chk("post_rst_accept", ctrl_valid_o, 1);
`else
    // DIV decodes as illegal and never goes busy
    cycle(1'b1, 2'b10, 6'b011010, 1'b0);
    chk("nomd_div_ill",  illegal_o, 1);
    chk("nomd_div_ctrl", ALUCtrl, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 2'b00, 6'b0, 1'b0);
      chk("nomd_busy", busy_o, 0);
    end
    // Async reset clears outputs; accept on first cycle after release
    cycle(1'b1, 2'b10, 6'b100011, 1'b0);
    rst = 1'b1;
    #1;
    chk_all_zero("nomd_rst_async");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    e_ctrl = 4'b0000;
    cycle(1'b1, 2'b01, 6'b0, 1'b0);
    chk("nomd_post_rst", ALUCtrl, 5'b00110);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic       v, fl;
      logic [1:0] op;
      logic [5:0] f;
      v  = ($urandom_range(0, 1) == 1);
      op = 2'($urandom_range(0, 3));
      f  = ($urandom_range(0, 1) == 1) ? fpool[$urandom_range(0, 9)] : 6'($urandom);
      fl = ($urandom_range(0, 39) == 0);
      cycle(v, op, f, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
